// File: rtl/simmem_linkedlist_bank_multi.sv
// Shared-storage message bank holding one in-order linked list per AXI ID.
// Each stored entry carries a payload, a valid bit and a next pointer. Each ID
// keeps a head, a tail and a length. New messages take the lowest free entry.
// Releases read the head of the selected list with zero latency.
// Optional feature, enabled by defining SIMMEM_LLBANK_BYPASS_EN: when the
// selected list is empty and a message for that same ID arrives, the message
// is presented on the output in the same cycle. If the consumer accepts it in
// that cycle, it passes through without using a storage entry.
module simmem_linkedlist_bank_multi #(
    parameter int MessageWidth  = 32,
    parameter int IdWidth       = 2,
    parameter int TotalCapacity = 16
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               in_valid_i,
    output logic                               in_ready_o,
    input  logic [IdWidth-1:0]                 in_id_i,
    input  logic [MessageWidth-1:0]            in_data_i,
    input  logic [IdWidth-1:0]                 out_id_i,
    output logic                               out_valid_o,
    input  logic                               out_ready_i,
    output logic [MessageWidth-1:0]            out_data_o,
    output logic [$clog2(TotalCapacity):0]     occupancy_o
);
    localparam int NumIds = 2 ** IdWidth;
    localparam int PtrW   = $clog2(TotalCapacity);
    localparam int LenW   = PtrW + 1;

    logic [MessageWidth-1:0] data_q [TotalCapacity];
    logic [TotalCapacity-1:0] valid_q, valid_d;
    logic [PtrW-1:0] next_q [TotalCapacity];
    logic [PtrW-1:0] next_d [TotalCapacity];
    logic [PtrW-1:0] head_q [NumIds];
    logic [PtrW-1:0] head_d [NumIds];
    logic [PtrW-1:0] tail_q [NumIds];
    logic [PtrW-1:0] tail_d [NumIds];
    logic [LenW-1:0] len_q  [NumIds];
    logic [LenW-1:0] len_d  [NumIds];

    logic [PtrW-1:0] alloc_idx;
    logic            free_any;
    logic [LenW-1:0] occ;
    logic [PtrW-1:0] sel_head;
    logic            stored_valid;
    logic            in_hs;
    logic            bypass;
    logic            bypass_take;
    logic            in_store;
    logic            out_rel;

    // Lowest-index free entry. A release frees its entry only at the next edge,
    // so a freed entry is never reallocated in the same cycle.
    always_comb begin
        alloc_idx = '0;
        free_any  = 1'b0;
        for (int i = TotalCapacity - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                alloc_idx = PtrW'(i);
                free_any  = 1'b1;
            end
        end
    end

    // Occupancy is the population count of the valid bits.
    always_comb begin
        occ = '0;
        for (int i = 0; i < TotalCapacity; i++) begin
            occ = occ + LenW'(valid_q[i]);
        end
    end

    assign occupancy_o  = occ;
    assign in_ready_o   = free_any;
    assign in_hs        = in_valid_i & free_any;
    assign sel_head     = head_q[out_id_i];
    assign stored_valid = (len_q[out_id_i] != '0);

`ifdef SIMMEM_LLBANK_BYPASS_EN
    assign bypass      = in_hs & ~stored_valid & (in_id_i == out_id_i);
    assign bypass_take = bypass & out_ready_i;
`else
    assign bypass      = 1'b0;
    assign bypass_take = 1'b0;
`endif

    assign in_store = in_hs & ~bypass_take;
    assign out_rel  = stored_valid & out_ready_i;

    // Output view of the selected list: bypass payload, stored head, or zero.
    always_comb begin
        out_valid_o = stored_valid | bypass;
        out_data_o  = '0;
        if (bypass) begin
            out_data_o = in_data_i;
        end else if (stored_valid) begin
            out_data_o = data_q[sel_head];
        end
    end

    // List update. The release is applied first. The append then sees the
    // post-release length. This way a same-ID append into a list that the
    // release just emptied becomes both the new head and the new tail.
    always_comb begin
        valid_d = valid_q;
        next_d  = next_q;
        head_d  = head_q;
        tail_d  = tail_q;
        len_d   = len_q;
        if (out_rel) begin
            valid_d[sel_head] = 1'b0;
            head_d[out_id_i]  = next_q[sel_head];
            len_d[out_id_i]   = len_q[out_id_i] - LenW'(1);
        end
        if (in_store) begin
            valid_d[alloc_idx] = 1'b1;
            if (len_d[in_id_i] == '0) begin
                head_d[in_id_i] = alloc_idx;
            end else begin
                next_d[tail_q[in_id_i]] = alloc_idx;
            end
            tail_d[in_id_i] = alloc_idx;
            len_d[in_id_i]  = len_d[in_id_i] + LenW'(1);
        end
    end

    // Payload storage is not reset. Entries are only read while they are valid.
    always_ff @(posedge clk_i) begin
        if (in_store) begin
            data_q[alloc_idx] <= in_data_i;
        end
    end

    // Bookkeeping registers, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            for (int i = 0; i < TotalCapacity; i++) begin
                next_q[i] <= '0;
            end
            for (int j = 0; j < NumIds; j++) begin
                head_q[j] <= '0;
                tail_q[j] <= '0;
                len_q[j]  <= '0;
            end
        end else begin
            valid_q <= valid_d;
            next_q  <= next_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            len_q   <= len_d;
        end
    end

endmodule

// File: tb/tb_simmem_linkedlist_bank_multi.sv
// Directed bench for simmem_linkedlist_bank_multi (16-bit messages, 4 IDs, 8 entries).
// Covers both builds, with and without SIMMEM_LLBANK_BYPASS_EN.
module tb_simmem_linkedlist_bank_multi;
    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [1:0]  in_id_i;
    logic [15:0] in_data_i;
    logic [1:0]  out_id_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [15:0] out_data_o;
    logic [3:0]  occupancy_o;

    int checks   = 0;
    int failures = 0;

    simmem_linkedlist_bank_multi #(
        .MessageWidth (16),
        .IdWidth      (2),
        .TotalCapacity(8)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_id_i     (in_id_i),
        .in_data_i   (in_data_i),
        .out_id_i    (out_id_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .occupancy_o (occupancy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic [1:0] id, input logic [15:0] data);
        in_valid_i = 1'b1;
        in_id_i    = id;
        in_data_i  = data;
        tick();
        in_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (in_ready_o !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready_o); end
        checks++; if (out_valid_o !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid_o); end
        checks++; if (out_data_o !== 16'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0000", out_data_o); end
        checks++; if (occupancy_o !== 4'd0) begin failures++; $display("FAIL reset_occ got=%0d exp=0", occupancy_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_in_order();
        logic [15:0] exp_d [3];
        exp_d[0] = 16'h000A; exp_d[1] = 16'h000B; exp_d[2] = 16'h000C;
        for (int i = 0; i < 3; i++) push(2'd1, exp_d[i]);
        checks++; if (occupancy_o !== 4'd3) begin failures++; $display("FAIL order_occ3 got=%0d exp=3", occupancy_o); end
        out_id_i    = 2'd1;
        out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (out_valid_o !== 1'b1 || out_data_o !== exp_d[i]) begin
                failures++; $display("FAIL order_data%0d got=%b/%h exp=1/%h", i, out_valid_o, out_data_o, exp_d[i]);
            end
            tick();
        end
        out_ready_i = 1'b0;
        #1;
        checks++; if (occupancy_o !== 4'd0 || out_valid_o !== 1'b0) begin
            failures++; $display("FAIL order_empty got=occ%0d/v%b exp=occ0/v0", occupancy_o, out_valid_o);
        end
    endtask

    task automatic test_interleave();
        push(2'd0, 16'h0010);
        push(2'd2, 16'h0020);
        push(2'd0, 16'h0011);
        out_id_i = 2'd3; #1;
        checks++; if (out_valid_o !== 1'b0 || out_data_o !== 16'h0) begin
            failures++; $display("FAIL inter_id3_a got=%b/%h exp=0/0000", out_valid_o, out_data_o);
        end
        out_id_i = 2'd2; out_ready_i = 1'b1; #1;
        checks++; if (out_valid_o !== 1'b1 || out_data_o !== 16'h0020) begin
            failures++; $display("FAIL inter_id2 got=%b/%h exp=1/0020", out_valid_o, out_data_o);
        end
        tick();
        out_ready_i = 1'b0; out_id_i = 2'd3; #1;
        checks++; if (out_valid_o !== 1'b0) begin failures++; $display("FAIL inter_id3_b got=%b exp=0", out_valid_o); end
        out_id_i = 2'd0; out_ready_i = 1'b1; #1;
        checks++; if (out_data_o !== 16'h0010) begin failures++; $display("FAIL inter_id0_a got=%h exp=0010", out_data_o); end
        tick();
        #1;
        checks++; if (out_data_o !== 16'h0011) begin failures++; $display("FAIL inter_id0_b got=%h exp=0011", out_data_o); end
        tick();
        out_ready_i = 1'b0;
        checks++; if (occupancy_o !== 4'd0) begin failures++; $display("FAIL inter_occ got=%0d exp=0", occupancy_o); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 8; i++) push(2'd0, 16'h0100 + 16'(i));
        checks++; if (in_ready_o !== 1'b0 || occupancy_o !== 4'd8) begin
            failures++; $display("FAIL full_state got=rdy%b/occ%0d exp=rdy0/occ8", in_ready_o, occupancy_o);
        end
        out_id_i = 2'd0; out_ready_i = 1'b1;
        in_valid_i = 1'b1; in_id_i = 2'd3; in_data_i = 16'hBEEF;
        #1;
        checks++; if (in_ready_o !== 1'b0 || out_data_o !== 16'h0100) begin
            failures++; $display("FAIL full_release_cycle got=rdy%b/%h exp=rdy0/0100", in_ready_o, out_data_o);
        end
        tick();
        out_ready_i = 1'b0;
        checks++; if (occupancy_o !== 4'd7 || in_ready_o !== 1'b1) begin
            failures++; $display("FAIL full_after_release got=occ%0d/rdy%b exp=occ7/rdy1", occupancy_o, in_ready_o);
        end
        tick();
        in_valid_i = 1'b0;
        out_id_i = 2'd3; #1;
        checks++; if (occupancy_o !== 4'd8 || out_data_o !== 16'hBEEF) begin
            failures++; $display("FAIL full_refill got=occ%0d/%h exp=occ8/beef", occupancy_o, out_data_o);
        end
        checks++; if (dut.head_q[3] !== 3'd0) begin failures++; $display("FAIL full_freed_index got=%0d exp=0", dut.head_q[3]); end
        out_id_i = 2'd0; out_ready_i = 1'b1;
        for (int i = 1; i < 8; i++) begin
            #1;
            checks++; if (out_data_o !== 16'h0100 + 16'(i)) begin
                failures++; $display("FAIL full_drain%0d got=%h exp=%h", i, out_data_o, 16'h0100 + 16'(i));
            end
            tick();
        end
        out_id_i = 2'd3;
        tick();
        out_ready_i = 1'b0;
        checks++; if (occupancy_o !== 4'd0) begin failures++; $display("FAIL full_drained_occ got=%0d exp=0", occupancy_o); end
    endtask

    task automatic test_same_id_len1();
        push(2'd1, 16'h0055);
        out_id_i = 2'd1; out_ready_i = 1'b1;
        in_valid_i = 1'b1; in_id_i = 2'd1; in_data_i = 16'h0066;
        #1;
        checks++; if (out_valid_o !== 1'b1 || out_data_o !== 16'h0055) begin
            failures++; $display("FAIL len1_out got=%b/%h exp=1/0055", out_valid_o, out_data_o);
        end
        tick();
        in_valid_i = 1'b0; out_ready_i = 1'b0; #1;
        checks++; if (out_data_o !== 16'h0066 || occupancy_o !== 4'd1 || dut.len_q[1] !== 4'd1) begin
            failures++; $display("FAIL len1_next got=%h/occ%0d/len%0d exp=0066/occ1/len1", out_data_o, occupancy_o, dut.len_q[1]);
        end
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        checks++; if (occupancy_o !== 4'd0) begin failures++; $display("FAIL len1_drain got=%0d exp=0", occupancy_o); end
    endtask

    task automatic test_same_id_len2();
        push(2'd2, 16'h00A1);
        push(2'd2, 16'h00A2);
        out_id_i = 2'd2; out_ready_i = 1'b1;
        in_valid_i = 1'b1; in_id_i = 2'd2; in_data_i = 16'h00A3;
        #1;
        checks++; if (out_data_o !== 16'h00A1) begin failures++; $display("FAIL len2_out got=%h exp=00a1", out_data_o); end
        tick();
        in_valid_i = 1'b0; #1;
        checks++; if (occupancy_o !== 4'd2 || out_data_o !== 16'h00A2) begin
            failures++; $display("FAIL len2_next got=occ%0d/%h exp=occ2/00a2", occupancy_o, out_data_o);
        end
        tick();
        #1;
        checks++; if (out_data_o !== 16'h00A3) begin failures++; $display("FAIL len2_last got=%h exp=00a3", out_data_o); end
        tick();
        out_ready_i = 1'b0;
    endtask

    task automatic test_diff_ids();
        push(2'd0, 16'h00C0);
        out_id_i = 2'd0; out_ready_i = 1'b1;
        in_valid_i = 1'b1; in_id_i = 2'd1; in_data_i = 16'h00D0;
        tick();
        in_valid_i = 1'b0; out_ready_i = 1'b0; #1;
        checks++; if (occupancy_o !== 4'd1 || out_valid_o !== 1'b0) begin
            failures++; $display("FAIL diff_state got=occ%0d/v%b exp=occ1/v0", occupancy_o, out_valid_o);
        end
        out_id_i = 2'd1; out_ready_i = 1'b1; #1;
        checks++; if (out_data_o !== 16'h00D0) begin failures++; $display("FAIL diff_id1 got=%h exp=00d0", out_data_o); end
        tick();
        out_ready_i = 1'b0;
    endtask

    task automatic test_bypass();
        out_id_i = 2'd2; out_ready_i = 1'b1;
        in_valid_i = 1'b1; in_id_i = 2'd2; in_data_i = 16'h0077;
        #1;
`ifdef SIMMEM_LLBANK_BYPASS_EN
        checks++; if (out_valid_o !== 1'b1 || out_data_o !== 16'h0077) begin
            failures++; $display("FAIL bypass_same got=%b/%h exp=1/0077", out_valid_o, out_data_o);
        end
        tick();
        in_valid_i = 1'b0; #1;
        checks++; if (occupancy_o !== 4'd0 || out_valid_o !== 1'b0) begin
            failures++; $display("FAIL bypass_after got=occ%0d/v%b exp=occ0/v0", occupancy_o, out_valid_o);
        end
`else
        checks++; if (out_valid_o !== 1'b0 || out_data_o !== 16'h0) begin
            failures++; $display("FAIL nobypass_same got=%b/%h exp=0/0000", out_valid_o, out_data_o);
        end
        tick();
        in_valid_i = 1'b0; #1;
        checks++; if (occupancy_o !== 4'd1 || out_valid_o !== 1'b1 || out_data_o !== 16'h0077) begin
            failures++; $display("FAIL nobypass_next got=occ%0d/%b/%h exp=occ1/1/0077", occupancy_o, out_valid_o, out_data_o);
        end
        tick();
`endif
        out_ready_i = 1'b0;
        checks++; if (occupancy_o !== 4'd0) begin failures++; $display("FAIL bypass_end_occ got=%0d exp=0", occupancy_o); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) push(2'(i % 2), 16'h0200 + 16'(i));
        out_id_i = 2'd0; #1;
        checks++; if (occupancy_o !== 4'd5 || out_valid_o !== 1'b1) begin
            failures++; $display("FAIL rstmid_pre got=occ%0d/v%b exp=occ5/v1", occupancy_o, out_valid_o);
        end
        rst_ni = 1'b0; #1;
        checks++; if (out_valid_o !== 1'b0 || occupancy_o !== 4'd0 || in_ready_o !== 1'b1 || out_data_o !== 16'h0) begin
            failures++; $display("FAIL rstmid got=v%b/occ%0d/rdy%b/%h exp=v0/occ0/rdy1/0000", out_valid_o, occupancy_o, in_ready_o, out_data_o);
        end
        #1 rst_ni = 1'b1;
        tick();
        out_id_i = 2'd1; #1;
        checks++; if (out_valid_o !== 1'b0) begin failures++; $display("FAIL rstmid_id1 got=%b exp=0", out_valid_o); end
    endtask

    initial begin
        rst_ni      = 1'b0;
        in_valid_i  = 1'b0;
        in_id_i     = 2'd0;
        in_data_i   = 16'h0;
        out_id_i    = 2'd0;
        out_ready_i = 1'b0;
        test_reset();
        test_in_order();
        test_interleave();
        test_full();
        test_same_id_len1();
        test_same_id_len2();
        test_diff_ids();
        test_bypass();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/simmem_linkedlist_bank_multi.md
SIMMEM_LINKEDLIST_BANK_MULTI -- requirements
Module: simmem_linkedlist_bank_multi

Interface
REQ-001 SHALL have parameter MessageWidth, default 32: width of one stored message.
REQ-002 SHALL have parameter IdWidth, default 2: width of the AXI ID; NumIds = 2**IdWidth independent in-order lists.
REQ-003 SHALL have parameter TotalCapacity, default 16: entries in the shared storage; power of two, >= 2.
REQ-004 clk_i  input  1  clock, all state on rising edge.
REQ-005 rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 in_valid_i  input  1  write request.
REQ-007 in_ready_o  output  1  storage can accept a message.
REQ-008 in_id_i  input  IdWidth  list the message is appended to.
REQ-009 in_data_i  input  MessageWidth  message payload.
REQ-010 out_id_i  input  IdWidth  list selected for release.
REQ-011 out_valid_o  output  1  selected list has a releasable message.
REQ-012 out_ready_i  input  1  consumer accepts the selected message.
REQ-013 out_data_o  output  MessageWidth  head message of the selected list.
REQ-014 occupancy_o  output  $clog2(TotalCapacity)+1  number of occupied entries.

Function
REQ-015 SHALL hold per entry: payload, valid bit, next pointer ($clog2(TotalCapacity) bits); per ID: head, tail, length ($clog2(TotalCapacity)+1 bits).
REQ-016 SHALL allocate the lowest-index entry whose valid bit is 0.
REQ-017 in_ready_o SHALL be 1 iff at least one entry is free; it SHALL NOT depend on out_ready_i or any same-cycle release.
REQ-018 On in handshake: set valid of the allocated entry, write payload, append it to list in_id_i (if length 0 head=tail=entry, else next[tail]=entry, tail=entry), length+1; all effective next cycle.
REQ-019 out_valid_o SHALL be 1 iff length[out_id_i] != 0; out_data_o SHALL be the payload at head[out_id_i], combinational from registered state (zero read latency).
REQ-020 On out handshake: clear valid of the head entry, head=next[head], length-1, effective next cycle.
REQ-021 Simultaneous in and out, different IDs: both SHALL complete in the same cycle independently.
REQ-022 Simultaneous in and out, same ID, length >= 2: append and release both SHALL complete; length unchanged.
REQ-023 Simultaneous in and out, same ID, length == 1: head SHALL become the newly allocated entry, tail likewise, length stays 1.
REQ-024 An entry freed by a release SHALL NOT be reallocated in the same cycle; it is allocatable from the next cycle.
REQ-025 occupancy_o SHALL equal the population count of valid bits, +1 / -1 / net 0 per cycle according to handshakes.
REQ-026 Messages of one ID SHALL leave in arrival order; messages of different IDs SHALL have no ordering relation.
REQ-027 out_data_o SHALL be 0 whenever out_valid_o is 0.

Reset
REQ-028 On rst_ni low, all valid bits, heads, tails, lengths, next pointers SHALL clear to 0 immediately; in_ready_o=1, out_valid_o=0, out_data_o=0, occupancy_o=0.
REQ-029 Reset mid-operation SHALL drop all stored messages; payload storage need not be cleared.

Configuration
REQ-030 Macro SIMMEM_LLBANK_BYPASS_EN: when defined, if length[out_id_i]==0 and in handshake with in_id_i==out_id_i, out_valid_o=1 and out_data_o=in_data_i combinationally; if out_ready_i=1 the message SHALL pass through without allocating an entry, otherwise it is stored per REQ-018.
REQ-031 Without SIMMEM_LLBANK_BYPASS_EN, a message written into an empty list SHALL become visible on out_valid_o one cycle after its in handshake, never the same cycle.

Verification (MessageWidth=16, IdWidth=2, TotalCapacity=8)
REQ-032 Write 0x0A,0x0B,0x0C on ID1, then release ID1 with out_ready_i=1 -> out_data_o 0x0A,0x0B,0x0C in order, occupancy_o 3->0.
REQ-033 Interleave writes ID0:0x10, ID2:0x20, ID0:0x11; select ID2 -> 0x20 first; then ID0 -> 0x10,0x11; ID3 out_valid_o=0 throughout.
REQ-034 Fill 8 entries -> in_ready_o=0; release one with in_valid_i=1 same cycle -> write not accepted that cycle, accepted next cycle into the freed index.
REQ-035 ID1 length 1 (0x55), same cycle write ID1 0x66 and release ID1 -> 0x55 out; next cycle out_data_o=0x66, length 1, occupancy_o 1.
REQ-036 Assert rst_ni low with 5 messages stored -> out_valid_o=0, occupancy_o=0, in_ready_o=1 before the next clock edge.
REQ-037 Empty ID2, write ID2 0x77 with out_id_i=2, out_ready_i=1 -> with SIMMEM_LLBANK_BYPASS_EN 0x77 out same cycle, occupancy_o stays 0; without it, out_valid_o next cycle, occupancy_o 1.
